// File: rtl/alu_pkg.sv
// alu_pkg: shared state encoding and default datapath sizes for the ALU blocks.
package alu_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;
endpackage

// File: rtl/multicycle_adder_if.sv
// multicycle_adder_if: operand/result handshake bundle for multicycle_adder.
interface multicycle_adder_if
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;
    logic             zero;
    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow, zero
    );
    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, overflow, zero
    );
endinterface

// File: rtl/multicycle_adder_chunk_adder.sv
// chunk_adder: combinational CHUNK-bit ripple of full-adder cells.
module chunk_adder
    import alu_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);
    logic [CHUNK:0] c;
    assign c[0] = ci;
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/multicycle_adder.sv
// multicycle_adder: WIDTH-bit add/sub computed CHUNK bits per cycle through one ripple stage.
module multicycle_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input logic              clk,
    input logic              rst_n,
    multicycle_adder_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = N > 1 ? $clog2(N) : 1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("multicycle_adder: WIDTH must be a multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             c_out_q, c_out_d, ovf_q, ovf_d, zero_q, zero_d;
    logic [31:0]      sh;
    logic [CHUNK-1:0] x, y, s;
    logic [WIDTH-1:0] merged;
    logic             co, c_msb, last;

    assign sh     = 32'(idx_q) * 32'(CHUNK);
    assign x      = CHUNK'(a_q >> sh);
    assign y      = CHUNK'(b_q >> sh);
    // Replace only the active chunk of the running sum with the stage result.
    assign merged = (sum_q & ~(WIDTH'({CHUNK{1'b1}}) << sh)) | (WIDTH'(s) << sh);
    assign last   = idx_q == IW'(N - 1);

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .x    (x),
        .y    (y),
        .ci   (carry_q),
        .s    (s),
        .co   (co),
        .c_msb(c_msb)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE: if (bus.in_valid) begin
                a_d     = bus.a;
                b_d     = bus.sub ? ~bus.b : bus.b;
                carry_d = bus.sub | bus.c_in;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                sum_d   = merged;
                carry_d = co;
                idx_d   = last ? idx_q : idx_q + 1'b1;
                if (last) begin
                    c_out_d = co;
                    ovf_d   = c_msb ^ co;
                    zero_d  = merged == '0;
                    state_d = DONE;
                end
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder: directed and random checks of the chunked adder against a full-width arithmetic model.
module tb_multicycle_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    bit          sel = 1'b0;
    logic [31:0] va = '0, vb = '0;
    logic        vcin = 1'b0, vsub = 1'b0, viv = 1'b0, vor = 1'b0;
    int          checks = 0, errors = 0;
    int unsigned t_acc = 0, t_prev = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multicycle_adder_if #(.WIDTH(32)) m0 ();
    multicycle_adder_if #(.WIDTH(32)) m1 ();

    assign m0.a = va;
    assign m0.b = vb;
    assign m0.c_in = vcin;
    assign m0.sub = vsub;
    assign m0.in_valid = viv & ~sel;
    assign m0.out_ready = vor & ~sel;
    assign m1.a = va;
    assign m1.b = vb;
    assign m1.c_in = vcin;
    assign m1.sub = vsub;
    assign m1.in_valid = viv & sel;
    assign m1.out_ready = vor & sel;

    multicycle_adder #(.WIDTH(32), .CHUNK(8))  u0 (.clk(clk), .rst_n(rst_n), .bus(m0));
    multicycle_adder #(.WIDTH(32), .CHUNK(32)) u1 (.clk(clk), .rst_n(rst_n), .bus(m1));

    logic        ir, ov, co, of, zr;
    logic [31:0] sm;
    assign ir = sel ? m1.in_ready  : m0.in_ready;
    assign ov = sel ? m1.out_valid : m0.out_valid;
    assign co = sel ? m1.c_out     : m0.c_out;
    assign of = sel ? m1.overflow  : m0.overflow;
    assign zr = sel ? m1.zero      : m0.zero;
    assign sm = sel ? m1.sum       : m0.sum;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Issues one operation at the current negedge and waits for its result.
    task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sb);
        logic [32:0] t;
        logic [31:0] be;
        int k;
        sel = s;
        chk("in_ready before issue", ir, 1);
        va = a; vb = b; vcin = cin; vsub = sb; viv = 1'b1;
        t_prev = t_acc;
        t_acc = cyc;
        @(negedge clk);
        viv = 1'b0; va = $urandom; vb = $urandom;
        k = 1;
        while (!ov && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, s ? 2 : 5);
        be = sb ? ~b : b;
        t = {1'b0, a} + {1'b0, be} + 33'(sb ? 1'b1 : cin);
        chk("sum", sm, t[31:0]);
        chk("c_out", co, t[32]);
        chk("overflow", of, (a[31] == be[31]) && (t[31] != a[31]));
        chk("zero", zr, t[31:0] == 0);
        chk("in_ready in DONE", ir, 0);
    endtask

    task automatic pop();
        vor = 1'b1; viv = 1'b0;
        @(negedge clk);
        vor = 1'b0;
        chk("pop in_ready", ir, 1);
        chk("pop out_valid", ov, 0);
    endtask

    initial begin
        logic [31:0] hs;
        logic        hc, ho, hz;
        int          seen;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            chk("rst sum", sm, 0);
            chk("rst flags", {co, of, zr}, 0);
            chk("rst in_ready", ir, 1);
            chk("rst out_valid", ov, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        issue(0, 32'hFFFF_FFFF, 32'h1, 0, 0);
        chk("t1 sum", sm, 32'h0);
        chk("t1 flags", {co, zr, of}, 3'b110);
        pop();
        issue(0, 32'h7FFF_FFFF, 32'h1, 0, 0);
        chk("t2 sum", sm, 32'h8000_0000);
        chk("t2 flags", {of, co, zr}, 3'b100);
        pop();
        issue(0, 32'd5, 32'd7, 1, 1);
        chk("t3a sum", sm, 32'hFFFF_FFFE);
        chk("t3a flags", {co, of}, 2'b00);
        pop();
        issue(0, 32'd7, 32'd7, 0, 1);
        chk("t3b sum", sm, 32'h0);
        chk("t3b flags", {co, zr}, 2'b11);
        pop();

        issue(0, 32'h1234_5678, 32'h0F0F_F0F0, 1, 0);
        hs = sm; hc = co; ho = of; hz = zr;
        for (int i = 0; i < 3; i++) begin
            viv = 1'b1; va = $urandom; vb = $urandom; vsub = 1'b1;
            @(negedge clk);
            chk("bp sum", sm, hs);
            chk("bp flags", {co, of, zr}, {hc, ho, hz});
            chk("bp in_ready", ir, 0);
            chk("bp out_valid", ov, 1);
        end
        pop();
        chk("idle hold sum", sm, hs);

        va = 32'h0F0F_0F0F; vb = 32'h0101_0101; vcin = 0; vsub = 0; viv = 1'b1;
        @(negedge clk);
        viv = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid-run rst sum", sm, 0);
        chk("mid-run rst flags", {co, of, zr}, 0);
        chk("mid-run rst in_ready", ir, 1);
        chk("mid-run rst out_valid", ov, 0);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (ov) seen++;
        end
        chk("no out_valid after rst", seen, 0);
        issue(0, 32'd3, 32'd4, 0, 0);
        chk("t5 sum", sm, 32'd7);
        pop();

        issue(1, 32'h0, 32'h0, 1, 0);
        chk("t6 sum", sm, 32'd1);
        chk("t6 c_out", co, 0);
        pop();
        issue(1, 32'h8000_0000, 32'h8000_0000, 0, 0);
        chk("t6 issue interval", t_acc - t_prev, 3);
        pop();

        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            issue(i >= 16, ra, rb, 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) begin
                viv = 1'b1; va = $urandom;
                @(negedge clk);
                chk("rand hold out_valid", ov, 1);
            end
            pop();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_adder.md
# multicycle_adder

Parametrised multi-cycle adder/subtractor for the ALU datapath. It adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, using one CHUNK-bit ripple stage and a registered carry. A valid/ready handshake sits on each side, and the result is reported with carry, signed-overflow and zero flags. It replaces a full-width combinational ripple where area matters more than latency.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of CHUNK
- CHUNK, 8, bits processed per cycle; CHUNK = WIDTH is legal
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  operands and mode present
- in_ready  out  1  block can accept; high only in IDLE
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- c_in  in  1  carry-in; ignored when sub=1
- sub  in  1  0: A+B+c_in; 1: A-B (A + ~B + 1)
- out_valid  out  1  result valid; high only in DONE
- out_ready  in  1  consumer takes result
- sum  out  WIDTH  result
- c_out  out  1  carry out of MSB; for sub, 1 = no borrow
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB
- zero  out  1  sum == 0

## Operation
- N = WIDTH/CHUNK.
- States: IDLE, RUN, DONE. Encoding is 2-bit binary.
- IDLE: in_ready=1. When in_valid is high, latch a, the effective B (~b if sub), and the carry (1 if sub, else c_in). Set chunk index to 0 and go to RUN.
- RUN: each cycle, add chunk[idx] of A and effective B with the carry register.
  - Write the CHUNK-bit partial sum into the sum register at chunk[idx].
  - Update the carry register with the stage carry-out.
  - On idx = N-1, also capture the carry into the MSB (for overflow), set c_out, overflow and zero, and go to DONE. Otherwise increment idx.
- DONE: out_valid=1. On out_ready, go to IDLE. Without out_ready, hold indefinitely.
- Operands are only accepted in IDLE. in_valid asserted in RUN or DONE is ignored and produces no side effects.
- sum, c_out, overflow and zero are registered. They change only during RUN and hold their values through DONE and the following IDLE, until the next operation starts writing them.
- Chunk index wraps nowhere: it is reset to 0 on each accept.

## Timing
- Reset: if rst_n is low at a clock edge, then after that edge:
  - state = IDLE, idx = 0, carry = 0
  - sum = 0, c_out = 0, overflow = 0, zero = 0
  - in_ready = 1, out_valid = 0
- Reset mid-RUN or mid-DONE discards the operation. No out_valid is produced for it.
- Handshake cycle is cycle 0. RUN spans cycles 1..N. out_valid first goes high in cycle N+1.
  - WIDTH=32, CHUNK=8: out_valid in cycle 5.
  - CHUNK=WIDTH: out_valid in cycle 2.
- A result is popped in the cycle where out_valid and out_ready are both high. in_ready rises the next cycle, so the minimum issue interval is N+2 cycles.
- in_ready and out_valid are decoded from the state register and are never high together.
- No combinational path from any input to any output.

## Structure
- The shared package alu_pkg holds:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - the default WIDTH and CHUNK values
- Sub-module chunk_adder: a combinational CHUNK-bit ripple of 1-bit full-adder cells.
  - Ports: x, y, ci, s, co, c_msb.
  - c_msb is the carry into bit CHUNK-1.
- multicycle_adder holds the FSM, operand/sum registers, carry register and index counter, and selects the slices feeding chunk_adder.
- Add an elaboration-time check: WIDTH % CHUNK == 0.

## Test plan
1. WIDTH=32, CHUNK=8, add a=0xFFFF_FFFF, b=0x1, c_in=0. Required: sum=0x0000_0000, c_out=1, zero=1, overflow=0, out_valid in cycle 5.
2. Add a=0x7FFF_FFFF, b=0x1, c_in=0. Required: sum=0x8000_0000, overflow=1, c_out=0, zero=0.
3. Sub a=5, b=7, c_in=1 (ignored). Required: sum=0xFFFF_FFFE, c_out=0, overflow=0. Then sub a=7, b=7. Required: sum=0, c_out=1, zero=1.
4. Backpressure: hold out_ready=0 for 3 cycles after out_valid rises, and drive in_valid=1 with new operands during that time. Required: sum and flags stable, in_ready=0, new operands ignored. Pop, then in_ready=1 on the next cycle.
5. Start an add, then drive rst_n=0 in cycle 2 for one cycle. Required: all outputs 0 and in_ready=1 after that edge, and no out_valid. Then a=3, b=4 gives sum=7.
6. CHUNK=WIDTH=32, add a=0, b=0, c_in=1. Required: sum=1, c_out=0, out_valid in cycle 2. Follow with a back-to-back issue at the minimum interval of 3 cycles.
